// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-driven single-port RAM controller behind the SPI slave
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  localparam logic [8:0]           DEPTH = 9'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(MEM_DEPTH - 1);

  logic [7:0] mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic                 wr_set_q, wr_set_d;
  logic                 rd_set_q, rd_set_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  logic                 mem_we;
  cmd_e                 cmd;
  logic                 in_range;
  logic [ADDR_SIZE-1:0] addr_in;

  function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
    if (!AUTO_INC) return p;
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign cmd      = cmd_e'(din[9:8]);
  assign in_range = {1'b0, din[7:0]} < DEPTH;
  assign addr_in  = ADDR_SIZE'(din[7:0]);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_set_d   = wr_set_q;
    rd_set_d   = rd_set_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          if (in_range) begin
            wr_ptr_d = addr_in;
            wr_set_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_WR_DATA: begin
          if (wr_set_q) begin
            mem_we   = !rst;
            wr_ptr_d = next_ptr(wr_ptr_q);
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          if (in_range) begin
            rd_ptr_d = addr_in;
            rd_set_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RD_DATA: begin
          if (rd_set_q) begin
            dout_d     = mem[rd_ptr_q];
            tx_valid_d = 1'b1;
            rd_ptr_d   = next_ptr(rd_ptr_q);
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // Array has no reset so contents survive rst and map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= din[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_set_q   <= 1'b0;
      rd_set_q   <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_set_q   <= wr_set_d;
      rd_set_q   <= rd_set_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule
